// File: rtl/ct_lsu_dcache_tag_ctrl_pkg.sv
// Shared dcache tag configuration: index width selection, way field layout, FSM states.
package ct_lsu_dcache_tag_ctrl_pkg;

`ifdef DCACHE_32K
    localparam int unsigned DCACHE_IDX_W = 8;
`else
    localparam int unsigned DCACHE_IDX_W = 9;
`endif

    localparam int unsigned TAG_IDX_W = 9;
    localparam int unsigned PTAG_W    = 25;
    localparam int unsigned VALID_BIT = 25;
    localparam int unsigned WAY_W     = 26;
    localparam int unsigned WAY_NUM   = 2;
    localparam int unsigned ENTRY_W   = WAY_W * WAY_NUM;

    typedef enum logic {
        SWEEP = 1'b0,
        IDLE  = 1'b1
    } tag_state_e;

endpackage

// File: rtl/ct_lsu_dcache_tag_ctrl_if.sv
// Request/response and tag-array signal bundle for the dcache tag controller.
interface ct_lsu_dcache_tag_ctrl_if
    import ct_lsu_dcache_tag_ctrl_pkg::*;
#(
    parameter int unsigned IDX_W = DCACHE_IDX_W
);
    logic                 rd_req_vld;
    logic [IDX_W-1:0]     rd_req_idx;
    logic [PTAG_W-1:0]    rd_req_ptag;
    logic                 rd_req_grnt;
    logic                 wr_req_vld;
    logic [IDX_W-1:0]     wr_req_idx;
    logic                 wr_req_way;
    logic [WAY_W-1:0]     wr_req_tag;
    logic                 wr_req_grnt;
    logic                 inv_all_req;
    logic                 inv_all_busy;
    logic                 inv_all_done;
    logic                 tag_gateclk_en;
    logic                 tag_sel_b;
    logic                 tag_gwen_b;
    logic [WAY_NUM-1:0]   tag_wen_b;
    logic [TAG_IDX_W-1:0] tag_idx;
    logic [ENTRY_W-1:0]   tag_din;
    logic [ENTRY_W-1:0]   tag_dout;
    logic                 rd_rsp_vld;
    logic [ENTRY_W-1:0]   rd_rsp_data;
    logic [WAY_NUM-1:0]   rd_rsp_hit_way;
    logic                 rd_rsp_hit;

    modport slave (
        input  rd_req_vld, rd_req_idx, rd_req_ptag,
        input  wr_req_vld, wr_req_idx, wr_req_way, wr_req_tag,
        input  inv_all_req, tag_dout,
        output rd_req_grnt, wr_req_grnt, inv_all_busy, inv_all_done,
        output tag_gateclk_en, tag_sel_b, tag_gwen_b, tag_wen_b, tag_idx, tag_din,
        output rd_rsp_vld, rd_rsp_data, rd_rsp_hit_way, rd_rsp_hit
    );

    modport master (
        output rd_req_vld, rd_req_idx, rd_req_ptag,
        output wr_req_vld, wr_req_idx, wr_req_way, wr_req_tag,
        output inv_all_req, tag_dout,
        input  rd_req_grnt, wr_req_grnt, inv_all_busy, inv_all_done,
        input  tag_gateclk_en, tag_sel_b, tag_gwen_b, tag_wen_b, tag_idx, tag_din,
        input  rd_rsp_vld, rd_rsp_data, rd_rsp_hit_way, rd_rsp_hit
    );
endinterface

// File: rtl/ct_lsu_dcache_tag_cmp.sv
// Single-way tag compare: hit when the way is valid and its ptag matches.
module ct_lsu_dcache_tag_cmp
    import ct_lsu_dcache_tag_ctrl_pkg::*;
(
    input  logic [WAY_W-1:0]  way_i,
    input  logic [PTAG_W-1:0] ptag_i,
    output logic              hit_o
);
    assign hit_o = way_i[VALID_BIT] && (way_i[PTAG_W-1:0] == ptag_i);
endmodule

// File: rtl/ct_lsu_dcache_tag_ctrl.sv
// Dcache tag-array access controller: invalidate sweep, write-over-read arbitration,
// and one-cycle-latency hit generation from the array read data.
module ct_lsu_dcache_tag_ctrl
    import ct_lsu_dcache_tag_ctrl_pkg::*;
#(
    parameter int unsigned IDX_W     = DCACHE_IDX_W,
    parameter int unsigned INDEX_NUM = 1 << IDX_W
)(
    input  logic                      forever_cpuclk,
    input  logic                      cpurst_b,
    ct_lsu_dcache_tag_ctrl_if.slave   bus
);
    localparam logic [IDX_W-1:0] CNT_LAST = IDX_W'(INDEX_NUM - 1);

    tag_state_e          state_q;
    logic [IDX_W-1:0]    cnt_q;
    logic                busy_q;
    logic                done_q;
    logic                rsp_vld_q;
    logic [PTAG_W-1:0]   ptag_q;

    logic                sweep;
    logic                wr_grnt;
    logic                rd_grnt;
    logic [IDX_W-1:0]    idx_sel;
    logic [WAY_NUM-1:0]  hit_way;

    // Array controls are combinational so reset already presents the sweep write of set 0.
    assign sweep   = (state_q == SWEEP);
    assign wr_grnt = !sweep && !bus.inv_all_req && bus.wr_req_vld;
    assign rd_grnt = !sweep && !bus.inv_all_req && !bus.wr_req_vld && bus.rd_req_vld;

    always_comb begin
        idx_sel = bus.rd_req_idx;
        if (sweep) begin
            idx_sel = cnt_q;
        end else if (wr_grnt) begin
            idx_sel = bus.wr_req_idx;
        end
    end

    always_comb begin
        bus.tag_wen_b = '1;
        if (sweep) begin
            bus.tag_wen_b = '0;
        end else if (wr_grnt) begin
            bus.tag_wen_b[bus.wr_req_way] = 1'b0;
        end
    end

    assign bus.rd_req_grnt    = rd_grnt;
    assign bus.wr_req_grnt    = wr_grnt;
    assign bus.tag_sel_b      = !(sweep || wr_grnt || rd_grnt);
    assign bus.tag_gateclk_en = !bus.tag_sel_b;
    assign bus.tag_gwen_b     = !(sweep || wr_grnt);
    assign bus.tag_idx        = TAG_IDX_W'(idx_sel);
    assign bus.tag_din        = wr_grnt ? {bus.wr_req_tag, bus.wr_req_tag} : '0;

    always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            state_q   <= SWEEP;
            cnt_q     <= '0;
            busy_q    <= 1'b1;
            done_q    <= 1'b0;
            rsp_vld_q <= 1'b0;
            ptag_q    <= '0;
        end else begin
            done_q    <= 1'b0;
            rsp_vld_q <= rd_grnt;
            if (rd_grnt) begin
                ptag_q <= bus.rd_req_ptag;
            end
            case (state_q)
                SWEEP: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == CNT_LAST) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                IDLE: begin
                    if (bus.inv_all_req) begin
                        state_q <= SWEEP;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q <= SWEEP;
                    cnt_q   <= '0;
                    busy_q  <= 1'b1;
                end
            endcase
        end
    end

    assign bus.inv_all_busy = busy_q;
    assign bus.inv_all_done = done_q;
    assign bus.rd_rsp_vld   = rsp_vld_q;
    assign bus.rd_rsp_data  = bus.tag_dout;

    ct_lsu_dcache_tag_cmp u_cmp_way0 (
        .way_i  (bus.tag_dout[WAY_W-1:0]),
        .ptag_i (ptag_q),
        .hit_o  (hit_way[0])
    );

    ct_lsu_dcache_tag_cmp u_cmp_way1 (
        .way_i  (bus.tag_dout[ENTRY_W-1:WAY_W]),
        .ptag_i (ptag_q),
        .hit_o  (hit_way[1])
    );

    assign bus.rd_rsp_hit_way = hit_way;
    assign bus.rd_rsp_hit     = |hit_way;
endmodule
